// File: rtl/dice_display.sv
// Two-digit dice display: dash when idle, rotating segment while rolling, latched BCD result after.
// Optional post-roll blink enabled by defining DICE_DISPLAY_BLINK_EN.
module dice_display #(
  parameter int unsigned REFRESH_LOG2 = 4,
  parameter int unsigned SPIN_LOG2    = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       rolling,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1, SHOW = 2'd2} state_t;

  localparam logic [REFRESH_LOG2-1:0] REF_ONE  = 1;
  localparam logic [SPIN_LOG2-1:0]    STEP_ONE = 1;

  state_t                  state_q, state_d;
  logic [REFRESH_LOG2-1:0] ref_cnt_q, ref_cnt_d;
  logic                    phase_q, phase_d;
  logic [SPIN_LOG2-1:0]    step_cnt_q, step_cnt_d;
  logic [2:0]              spin_idx_q, spin_idx_d;
  logic [3:0]              held_tens_q, held_tens_d, held_ones_q, held_ones_d;
  logic [6:0]              seg_d;
  logic [1:0]              dig_d;
  logic                    valid_d;
  logic                    step_wrap, blank;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = 7'h79;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rolling)  state_d = SPIN;
      SPIN:    if (!rolling) state_d = SHOW;
      SHOW:    if (rolling)  state_d = SPIN;
      default: state_d = IDLE;
    endcase
  end

  // Step counter restarts on every state change so spin and blink both begin from step 0.
  always_comb begin
    step_wrap   = &step_cnt_q;
    ref_cnt_d   = ref_cnt_q + REF_ONE;
    phase_d     = (&ref_cnt_q) ? ~phase_q : phase_q;
    step_cnt_d  = '0;
    spin_idx_d  = spin_idx_q;
    held_tens_d = held_tens_q;
    held_ones_d = held_ones_q;
    if (state_d == state_q && state_q != IDLE) step_cnt_d = step_cnt_q + STEP_ONE;
    if (state_d == SPIN && state_q != SPIN) begin
      spin_idx_d = 3'd0;
    end else if (state_q == SPIN && step_wrap) begin
      spin_idx_d = (spin_idx_q == 3'd5) ? 3'd0 : spin_idx_q + 3'd1;
    end
    if (state_q == SPIN && state_d == SHOW) begin
      held_tens_d = tens;
      held_ones_d = ones;
    end
  end

`ifdef DICE_DISPLAY_BLINK_EN
  logic [2:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (state_d != SHOW)                              blink_d = 3'd0;
    else if (state_q != SHOW)                         blink_d = 3'd0;
    else if (step_wrap && blink_q != 3'd6)            blink_d = blink_q + 3'd1;
    blank = blink_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 3'd0;
    else        blink_q <= blink_d;
  end
`else
  assign blank = 1'b0;
`endif

  // Outputs are derived from next-state values so a state change shows on the same edge.
  always_comb begin
    seg_d   = 7'h00;
    dig_d   = phase_q ? 2'b10 : 2'b01;
    valid_d = (state_d == SHOW);
    case (state_d)
      IDLE: seg_d = 7'h40;
      SPIN: seg_d = 7'b000_0001 << spin_idx_d;
      SHOW: begin
        if (blank)
          seg_d = 7'h00;
        else if (phase_q)
          seg_d = (held_tens_d == 4'd0 && held_ones_d != 4'd0) ? 7'h00 : seg_of(held_tens_d);
        else
          seg_d = seg_of(held_ones_d);
      end
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ref_cnt_q   <= '0;
      phase_q     <= 1'b0;
      step_cnt_q  <= '0;
      spin_idx_q  <= 3'd0;
      held_tens_q <= 4'd0;
      held_ones_q <= 4'd0;
      seg         <= 7'h00;
      dig         <= 2'b00;
      valid       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      phase_q     <= phase_d;
      step_cnt_q  <= step_cnt_d;
      spin_idx_q  <= spin_idx_d;
      held_tens_q <= held_tens_d;
      held_ones_q <= held_ones_d;
      seg         <= seg_d;
      dig         <= dig_d;
      valid       <= valid_d;
    end
  end

endmodule

// File: tb/tb_dice_display.sv
// Directed bench for dice_display with REFRESH_LOG2=2, SPIN_LOG2=3.
module tb_dice_display;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rolling = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic [6:0] seg;
  logic [1:0] dig;
  logic       valid;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  dice_display #(.REFRESH_LOG2(2), .SPIN_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .tens(tens), .ones(ones), .rolling(rolling),
    .seg(seg), .dig(dig), .valid(valid)
  );

  typedef struct {
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] exp_ones;
    logic [6:0] exp_tens;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Digit phase model: 4 edges per digit, starting with ones on the first edge after release.
  function automatic logic [1:0] exp_dig();
    return (((edge_n - 1) / 4) % 2 != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [6:0] spin_seg(input int k);
    logic [6:0] s;
    s = 7'h01;
    return s << ((k / 8) % 6);
  endfunction

  function automatic bit blanked(input int k);
`ifdef DICE_DISPLAY_BLINK_EN
    return (k >= 8 && k < 16) || (k >= 24 && k < 32) || (k >= 40 && k < 48);
`else
    return (k < 0);
`endif
  endfunction

  task automatic latch(input logic [3:0] t, input logic [3:0] o);
    rolling = 1'b1;
    tick;
    tens = t;
    ones = o;
    rolling = 1'b0;
    tick;
    tens = ~t;
    ones = ~o;
  endtask

  task automatic show_check(input string nm, input logic [6:0] eo, input logic [6:0] et, input bit blank);
    logic [1:0] d;
    d = exp_dig();
    chk({nm, ".dig"}, dig, d);
    chk({nm, ".seg"}, seg, blank ? 7'h00 : (d == 2'b01 ? eo : et));
    chk({nm, ".valid"}, valid, 1);
  endtask

  initial begin
    vecs[0] = '{4'd1, 4'd7, 7'h07, 7'h06};
    vecs[1] = '{4'd0, 4'd4, 7'h66, 7'h00};
    vecs[2] = '{4'd0, 4'd0, 7'h3F, 7'h3F};
    vecs[3] = '{4'hC, 4'd3, 7'h4F, 7'h79};
    vecs[4] = '{4'd9, 4'd9, 7'h6F, 7'h6F};
    vecs[5] = '{4'd4, 4'd2, 7'h5B, 7'h66};
    vecs[6] = '{4'd0, 4'hF, 7'h79, 7'h00};
    vecs[7] = '{4'd8, 4'd5, 7'h6D, 7'h7F};

    // Held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst.seg", seg, 7'h00);
    chk("rst.dig", dig, 2'b00);
    chk("rst.valid", valid, 0);
    rst_n = 1'b1;
    edge_n = 0;

    // Idle dash with scanning digits
    for (int k = 0; k < 16; k++) begin
      tick;
      chk("idle.dig", dig, exp_dig());
      chk("idle.seg", seg, 7'h40);
      chk("idle.valid", valid, 0);
    end

    // Spin rotation for 50 cycles
    rolling = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick;
      chk("spin.seg", seg, spin_seg(k));
      chk("spin.dig", dig, exp_dig());
      chk("spin.valid", valid, 0);
    end

    // Latched results; inputs are scrambled right after latching
    for (int v = 0; v < 8; v++) begin
      latch(vecs[v].t, vecs[v].o);
      for (int k = 0; k < 8; k++) begin
        if (k > 0) tick;
        show_check($sformatf("vec%0d", v), vecs[v].exp_ones, vecs[v].exp_tens, blanked(k));
      end
    end

    // Long SHOW: blink window (when enabled) then steady
    latch(4'd2, 4'd0);
    for (int k = 0; k < 56; k++) begin
      if (k > 0) tick;
      show_check($sformatf("blink_k%0d", k), 7'h3F, 7'h5B, blanked(k));
    end

    // Re-roll at cycle 20 of SHOW, then blink restarts from 0
    latch(4'd2, 4'd0);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick;
      show_check("abort_pre", 7'h3F, 7'h5B, blanked(k));
    end
    rolling = 1'b1;
    tick;
    chk("abort.spin_seg", seg, 7'h01);
    chk("abort.valid", valid, 0);
    tens = 4'd2;
    ones = 4'd0;
    rolling = 1'b0;
    tick;
    tens = 4'd5;
    ones = 4'd5;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick;
      show_check($sformatf("restart_k%0d", k), 7'h3F, 7'h5B, blanked(k));
    end

    // Asynchronous reset mid-SHOW
    rst_n = 1'b0;
    #1;
    chk("arst.seg", seg, 7'h00);
    chk("arst.dig", dig, 2'b00);
    chk("arst.valid", valid, 0);
    @(posedge clk);
    #1;
    chk("arst_hold.seg", seg, 7'h00);
    chk("arst_hold.valid", valid, 0);
    rst_n = 1'b1;
    edge_n = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("post_rst.dig", dig, exp_dig());
      chk("post_rst.seg", seg, 7'h40);
      chk("post_rst.valid", valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
